// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes and multi-beat
// AND/OR accumulation of IN1 across bursts terminated by IN_LAST.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic [2:0]       i_op,
  input  logic             i_in_last,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_zero,
  output logic [CNT_W-1:0] o_out_cnt,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_NAND    = 3'd4;
  localparam logic [2:0] OP_NOR     = 3'd5;
  localparam logic [2:0] OP_ACC_AND = 3'd6;
  localparam logic [2:0] OP_ACC_OR  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_started;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_acc_or;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_zero;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_valid;

  logic [2:0]       w_op_eff;
  logic             w_is_acc;
  logic             w_in_hs;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_fold;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [0:0]       w_state_next;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_acc_or_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load;
  logic [WIDTH-1:0] w_res;
  logic [CNT_W-1:0] w_res_cnt;

  function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = a;
    endcase
    return r;
  endfunction

  // Without accumulation support, codes 6/7 degrade to a plain AND.
  generate
    if (ACC_EN != 0) begin : g_acc_on
      assign w_op_eff = i_op;
    end else begin : g_acc_off
      assign w_op_eff = (i_op[2:1] == 2'b11) ? OP_AND : i_op;
    end
  endgenerate

  assign w_is_acc = (w_op_eff == OP_ACC_AND) || (w_op_eff == OP_ACC_OR);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_single[gi] = bit_op(w_op_eff, i_in1[gi], i_in2[gi]);
      assign w_fold[gi]   = r_acc_or ? (r_acc[gi] | i_in1[gi]) : (r_acc[gi] & i_in1[gi]);
    end
  endgenerate

  assign w_cnt_inc  = (&r_cnt) ? r_cnt : (r_cnt + CNT_ONE);
  assign o_in_ready = r_started & (~r_out_valid | i_out_ready);
  assign w_in_hs    = i_in_valid & o_in_ready;

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_acc_or_next = r_acc_or;
    w_cnt_next    = r_cnt;
    w_load        = 1'b0;
    w_res         = w_single;
    w_res_cnt     = CNT_ONE;
    if (w_in_hs) begin
      if (r_state == S_ACCUM) begin
        // Mid-burst beats use the op latched at burst start; OP is ignored.
        w_acc_next = w_fold;
        w_cnt_next = w_cnt_inc;
        if (i_in_last) begin
          w_load       = 1'b1;
          w_res        = w_fold;
          w_res_cnt    = w_cnt_inc;
          w_state_next = S_IDLE;
          w_acc_next   = '0;
          w_cnt_next   = '0;
        end
      end else if (w_is_acc) begin
        if (i_in_last) begin
          w_load = 1'b1;
          w_res  = i_in1;
        end else begin
          w_acc_next    = i_in1;
          w_acc_or_next = (w_op_eff == OP_ACC_OR);
          w_cnt_next    = CNT_ONE;
          w_state_next  = S_ACCUM;
        end
      end else begin
        w_load = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started   <= 1'b0;
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_acc_or    <= 1'b0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_zero  <= 1'b1;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_acc_or  <= w_acc_or_next;
      r_cnt     <= w_cnt_next;
      if (w_load) begin
        r_out       <= w_res;
        r_out_zero  <= ~|w_res;
        r_out_cnt   <= w_res_cnt;
        r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out       = r_out;
  assign o_out_zero  = r_out_zero;
  assign o_out_cnt   = r_out_cnt;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop and compare.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in1, in2;
  logic [2:0] op;
  logic       last;
  logic       v1, v2;
  logic       ordy1, ordy2;

  logic       rdy1, z1, ov1;
  logic [7:0] out1, cnt1;
  logic       rdy2, z2, ov2;
  logic [7:0] out2;
  logic [1:0] cnt2;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8), .ACC_EN(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in1(in1), .i_in2(in2), .i_op(op),
    .i_in_last(last), .i_in_valid(v1), .o_in_ready(rdy1), .o_out(out1),
    .o_out_zero(z1), .o_out_cnt(cnt1), .o_out_valid(ov1), .i_out_ready(ordy1)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2), .ACC_EN(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in1(in1), .i_in2(in2), .i_op(op),
    .i_in_last(last), .i_in_valid(v2), .o_in_ready(rdy2), .o_out(out2),
    .o_out_zero(z2), .o_out_cnt(cnt2), .o_out_valid(ov2), .i_out_ready(ordy2)
  );

  typedef struct {
    logic [7:0] out;
    logic       zero;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov1 && ordy1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_out actual=%0h required=none", out1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_out", 32'(out1), 32'(e1.out));
        chk("dut1_zero", 32'(z1), 32'(e1.zero));
        chk("dut1_cnt", 32'(cnt1), 32'(e1.cnt));
        if (e1.cyc >= 0) chk("dut1_latency", 32'(cyc), 32'(e1.cyc));
        $display("dut1 result out=%02h zero=%0d cnt=%0d", out1, z1, cnt1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov2 && ordy2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_out actual=%0h required=none", out2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_out", 32'(out2), 32'(e2.out));
        chk("dut2_zero", 32'(z2), 32'(e2.zero));
        chk("dut2_cnt", 32'(cnt2), 32'(e2.cnt));
        $display("dut2 result out=%02h zero=%0d cnt=%0d", out2, z2, cnt2);
      end
    end
  end

  // One input beat; pushes the expected result when the beat completes an output.
  task automatic beat(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input logic l, input logic exp_en,
                      input logic [7:0] eo, input logic [7:0] ec, input logic lat);
    logic got;
    exp_t e;
    got  = 1'b0;
    in1  = a;
    in2  = b;
    op   = o;
    last = l;
    if (sel == 1) v1 = 1'b1; else v2 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if ((sel == 1) ? rdy1 : rdy2) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else if (exp_en) begin
      e.out  = eo;
      e.zero = (eo == 8'h00);
      e.cnt  = ec;
      e.cyc  = lat ? cyc + 1 : -1;
      if (sel == 1) q1.push_back(e); else q2.push_back(e);
    end
    $display("beat dut%0d in1=%02h in2=%02h op=%0d last=%0d", sel, a, b, o, l);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  logic [7:0] exp_ops [6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_ops = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'hCF, 8'h03};
    rst_n = 1'b0;
    in1 = '0; in2 = '0; op = '0; last = 1'b0;
    v1 = 1'b0; v2 = 1'b0; ordy1 = 1'b1; ordy2 = 1'b1;

    #12;
    chk("reset_out", 32'(out1), 32'h0);
    chk("reset_zero", 32'(z1), 32'h1);
    chk("reset_cnt", 32'(cnt1), 32'h0);
    chk("reset_valid", 32'(ov1), 32'h0);
    chk("reset_in_ready", 32'(rdy1), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(rdy1), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      beat(1, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b1, exp_ops[i], 8'd1, 1'b1);
    beat(1, 8'hF0, 8'h3C, 3'd0, 1'b1, 1'b1, 8'h30, 8'd1, 1'b1);

    beat(1, 8'hFF, 8'hAA, 3'd6, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(1, 8'h7E, 8'hAA, 3'd6, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(1, 8'h3C, 8'hAA, 3'd6, 1'b1, 1'b1, 8'h3C, 8'd3, 1'b1);

    beat(1, 8'h00, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(1, 8'h00, 8'hFF, 3'd0, 1'b1, 1'b1, 8'h00, 8'd2, 1'b1);
    beat(1, 8'h01, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(1, 8'h80, 8'hFF, 3'd0, 1'b1, 1'b1, 8'h81, 8'd2, 1'b1);
    beat(1, 8'hA5, 8'h00, 3'd7, 1'b1, 1'b1, 8'hA5, 8'd1, 1'b1);

    beat(1, 8'h0F, 8'hFF, 3'd3, 1'b0, 1'b1, 8'hF0, 8'd1, 1'b0);
    ordy1 = 1'b0;
    in1 = 8'h12; in2 = 8'h40; op = 3'd1; last = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(rdy1), 32'h0);
      chk("stall_valid", 32'(ov1), 32'h1);
      chk("stall_out", 32'(out1), 32'hF0);
      chk("stall_cnt", 32'(cnt1), 32'h1);
    end
    @(posedge clk); #1;
    ordy1 = 1'b1;
    beat(1, 8'h12, 8'h40, 3'd1, 1'b0, 1'b1, 8'h52, 8'd1, 1'b1);

    beat(2, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(2, 8'h02, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(2, 8'h04, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(2, 8'h08, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(2, 8'h10, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(2, 8'h20, 8'h00, 3'd7, 1'b1, 1'b1, 8'h3F, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    beat(1, 8'h0F, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    beat(1, 8'hF0, 8'h00, 3'd7, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", 32'(out1), 32'h0);
    chk("midreset_zero", 32'(z1), 32'h1);
    chk("midreset_cnt", 32'(cnt1), 32'h0);
    chk("midreset_valid", 32'(ov1), 32'h0);
    chk("midreset_in_ready", 32'(rdy1), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("midreset_ready_before_edge", 32'(rdy1), 32'h0);
    @(posedge clk); #1;
    beat(1, 8'h55, 8'h00, 3'd6, 1'b1, 1'b1, 8'h55, 8'd1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("dut1_results_outstanding", 32'(q1.size()), 32'h0);
    chk("dut2_results_outstanding", 32'(q2.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
